stage_if: RTL and testbench

//  Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of stage_ID.

---
 rtl/stage_if.sv | 166 ++++++++++++++++
 tb/tb_stage_if.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/stage_if.sv
// -----------------------------------------------------------------------------
// stage_if -- instruction-fetch stage of the 5-stage MIPS pipeline.
//
// Owns the PC and fetches from instruction memory over a req/ack handshake
// that tolerates wait states. Owns the IF/ID pipeline register and applies
// branch/jump targets resolved in ID. Branches have one delay slot, so
// nothing fetched is ever flushed.
//
// Handshake: imem_req is held high at a constant imem_addr (== pc) until
// imem_ack pulses; imem_rdata is valid in that ack cycle. imem_ack seen while
// imem_req is low is ignored. pc changes only when an instruction is
// accepted into IF/ID.
//
// Optional feature: define IF_PERF_CNT_EN to add fetch_cnt / wait_cnt.
//
// Ports
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous active-low reset
//   imem_req     out  1   fetch request
//   imem_addr    out  32  fetch address (== pc, word aligned)
//   imem_ack     in   1   one-cycle pulse, imem_rdata valid
//   imem_rdata   in   32  fetched instruction word
//   Stall_ID     in   1   ID holds; IF/ID must not change
//   Redirect_ID  in   1   taken branch / jump in ID this cycle
//   Address_ID   in   32  redirect target ([1:0] forced to 0)
//   Instr_ID     out  32  IF/ID instruction (0 = nop when not valid)
//   pc4_ID       out  32  IF/ID PC+4 of Instr_ID
//   valid_ID     out  1   Instr_ID is a real fetched instruction
//   dbg_state    out  1   FSM state (0 = FETCH, 1 = HOLD)
//   fetch_cnt    out  32  (IF_PERF_CNT_EN) accepted instructions, saturating
//   wait_cnt     out  32  (IF_PERF_CNT_EN) FETCH cycles waiting on ack
// -----------------------------------------------------------------------------
module stage_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        Stall_ID,
  input  logic        Redirect_ID,
  input  logic [31:0] Address_ID,
  output logic [31:0] Instr_ID,
  output logic [31:0] pc4_ID,
  output logic        valid_ID,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] fetch_cnt,
  output logic [31:0] wait_cnt,
`endif
  output logic        dbg_state
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_hold_buf;
  logic        r_pend_v;
  logic [31:0] r_pend_tgt;
  logic [31:0] r_instr_id;
  logic [31:0] r_pc4_id;
  logic        r_valid_id;

  logic        w_fetch_ack;
  logic        w_accept;
  logic [31:0] w_word;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_tgt;
  logic [31:0] w_npc;

  // An ack only counts while a request is outstanding (FETCH state).
  assign w_fetch_ack = (r_state == FETCH) && imem_ack;

  // Accept: a word moves into IF/ID, either straight from memory or from
  // the hold buffer once ID releases its stall.
  assign w_accept = (w_fetch_ack && !Stall_ID) ||
                    ((r_state == HOLD) && !Stall_ID);

  assign w_word     = (r_state == HOLD) ? r_hold_buf : imem_rdata;
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_tgt      = Address_ID & 32'hFFFF_FFFC;

  // A redirect this cycle beats an older pending one (newest wins).
  always_comb begin
    w_npc = w_pc_plus4;
    if (Redirect_ID)   w_npc = w_tgt;
    else if (r_pend_v) w_npc = r_pend_tgt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_hold_buf <= 32'h0;
      r_pend_v   <= 1'b0;
      r_pend_tgt <= 32'h0;
      r_instr_id <= 32'h0;
      r_pc4_id   <= 32'h0;
      r_valid_id <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_fetch_ack && Stall_ID) begin
            r_hold_buf <= imem_rdata;
            r_state    <= HOLD;
          end
        end
        HOLD: begin
          if (!Stall_ID) r_state <= FETCH;
        end
        default: r_state <= FETCH;
      endcase

      // IF/ID register: hold on stall, load on accept, otherwise bubble.
      if (w_accept) begin
        r_instr_id <= w_word;
        r_pc4_id   <= w_pc_plus4;
        r_valid_id <= 1'b1;
        r_pc       <= w_npc;
        r_pend_v   <= 1'b0;
      end else if (!Stall_ID) begin
        r_instr_id <= 32'h0;
        r_valid_id <= 1'b0;
      end

      // The delay slot has not been accepted yet: remember the target.
      if (Redirect_ID && !w_accept) begin
        r_pend_tgt <= w_tgt;
        r_pend_v   <= 1'b1;
      end
    end
  end

  assign imem_req  = (r_state == FETCH);
  assign imem_addr = r_pc;
  assign Instr_ID  = r_instr_id;
  assign pc4_ID    = r_pc4_id;
  assign valid_ID  = r_valid_id;
  assign dbg_state = r_state;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_wait_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_cnt <= 32'h0;
      r_wait_cnt  <= 32'h0;
    end else begin
      if (w_accept && (r_fetch_cnt != 32'hFFFF_FFFF))
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if ((r_state == FETCH) && !imem_ack && (r_wait_cnt != 32'hFFFF_FFFF))
        r_wait_cnt <= r_wait_cnt + 32'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign wait_cnt  = r_wait_cnt;
`endif

endmodule

// File: tb/tb_stage_if.sv
module tb_stage_if;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        Stall_ID;
  logic        Redirect_ID;
  logic [31:0] Address_ID;
  logic [31:0] Instr_ID;
  logic [31:0] pc4_ID;
  logic        valid_ID;
  logic        dbg_state;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] wait_cnt;
`endif

  int n_checks;
  int n_errors;

  // Expected IF/ID deliveries, {Instr_ID, pc4_ID}.
  logic [63:0] exp_q[$];

  stage_if #(.RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .Stall_ID    (Stall_ID),
    .Redirect_ID (Redirect_ID),
    .Address_ID  (Address_ID),
    .Instr_ID    (Instr_ID),
    .pc4_ID      (pc4_ID),
    .valid_ID    (valid_ID),
`ifdef IF_PERF_CNT_EN
    .fetch_cnt   (fetch_cnt),
    .wait_cnt    (wait_cnt),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  // IF/ID content is new whenever the preceding edge saw Stall_ID low.
  logic stall_q;
  always @(posedge clk) stall_q <= Stall_ID;

  always @(negedge clk) begin
    if (rst && !stall_q && valid_ID) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_delivery: got instr %h pc4 %h, none expected", Instr_ID, pc4_ID);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({Instr_ID, pc4_ID} !== e) begin
          n_errors++;
          $display("FAIL delivery: got instr %h pc4 %h expected instr %h pc4 %h",
                   Instr_ID, pc4_ID, e[63:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Apply inputs for one cycle; returns at 1 time unit after the edge.
  task automatic step(input logic ack, input logic [31:0] rdata, input logic stall,
                      input logic redir, input logic [31:0] tgt);
    imem_ack    = ack;
    imem_rdata  = rdata;
    Stall_ID    = stall;
    Redirect_ID = redir;
    Address_ID  = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] w, input logic [31:0] pc4);
    exp_q.push_back({w, pc4});
    step(1'b1, w, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; Stall_ID = 1'b0;
    Redirect_ID = 1'b0; Address_ID = 32'h0;

    // 1. reset / boot
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {31'h0, valid_ID}, 32'h0);
    chk("reset_instr", Instr_ID, 32'h0);
    chk("reset_pc4", pc4_ID, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("boot_req", {31'h0, imem_req}, 32'h1);
    chk("boot_addr", imem_addr, 32'h0000_3000);

    // 2. zero-wait streaming
    fetch(32'h2408_0001, 32'h3004);
    chk("stream_addr1", imem_addr, 32'h3004);
    fetch(32'h2409_0002, 32'h3008);
    fetch(32'h240A_0003, 32'h300C);
    fetch(32'h240B_0004, 32'h3010);
    chk("stream_addr4", imem_addr, 32'h3010);

    // 3. wait states: two bubbles, stable address
    idle();
    chk("wait_addr1", imem_addr, 32'h3010);
    chk("wait_bubble1", {31'h0, valid_ID}, 32'h0);
    chk("wait_nop1", Instr_ID, 32'h0);
    idle();
    chk("wait_addr2", imem_addr, 32'h3010);
    chk("wait_req2", {31'h0, imem_req}, 32'h1);
    fetch(32'h8C01_0010, 32'h3014);
    chk("wait_addr3", imem_addr, 32'h3014);

    // 4. stall during ack -> HOLD
    exp_q.push_back({32'hAC02_0020, 32'h3018});
    step(1'b1, 32'hAC02_0020, 1'b1, 1'b0, 32'h0);
    chk("hold_state", {31'h0, dbg_state}, 32'h1);
    chk("hold_req", {31'h0, imem_req}, 32'h0);
    chk("hold_instr", Instr_ID, 32'h8C01_0010);
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0); // ack while idle: ignored
    chk("hold_pc4", pc4_ID, 32'h3014);
    chk("hold_addr", imem_addr, 32'h3014);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    idle();
    chk("release_instr", Instr_ID, 32'hAC02_0020);
    chk("release_addr", imem_addr, 32'h3018);
    chk("release_req", {31'h0, imem_req}, 32'h1);

    // 5. pending redirect while the delay-slot fetch waits
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_3101);
    chk("pend_addr", imem_addr, 32'h3018);
    fetch(32'h0000_0020, 32'h301C);
    chk("pend_target", imem_addr, 32'h3100);

    // redirect together with accept
    exp_q.push_back({32'h1111_0001, 32'h3104});
    step(1'b1, 32'h1111_0001, 1'b0, 1'b1, 32'h0000_4000);
    chk("redir_same_addr", imem_addr, 32'h4000);
    fetch(32'h1111_0002, 32'h4004);

    // PC wrap at the top of the address space
    exp_q.push_back({32'h1111_0003, 32'h4008});
    step(1'b1, 32'h1111_0003, 1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    fetch(32'h1111_0004, 32'h0000_0000);
    chk("wrap_addr", imem_addr, 32'h0);

    // 6. reset while in HOLD with a pending redirect
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_5000);
    step(1'b1, 32'h2222_0001, 1'b1, 1'b0, 32'h0);  // discarded by reset
    chk("pre_reset_state", {31'h0, dbg_state}, 32'h1);
    rst = 1'b0;
    Stall_ID = 1'b0;
    imem_ack = 1'b0;
    #2;
    chk("mid_reset_valid", {31'h0, valid_ID}, 32'h0);
    chk("mid_reset_instr", Instr_ID, 32'h0);
    chk("mid_reset_pc4", pc4_ID, 32'h0);
    chk("mid_reset_addr", imem_addr, 32'h3000);
    chk("mid_reset_state", {31'h0, dbg_state}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_req", {31'h0, imem_req}, 32'h1);
    fetch(32'h3333_0001, 32'h3004);
    chk("post_reset_addr", imem_addr, 32'h3004);
    fetch(32'h3333_0002, 32'h3008);
    idle();
    idle();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL queue_drain: %0d deliveries outstanding, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
